// File: rtl/core_cf_arbiter.sv
// Control-flow redirect arbiter: merges writeback and execute redirects onto one fetch bus.
// Optional saturating perf counters are built when CORE_CF_ARB_PERF_EN is defined.
module core_cf_arbiter #(
  parameter int XLEN = 64,
  parameter int CW   = 32
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            wb_req_valid,
  input  logic [XLEN-1:0] wb_req_target,
  output logic            wb_req_ack,
  input  logic            ex_req_valid,
  input  logic [XLEN-1:0] ex_req_target,
  output logic            ex_req_ack,
  output logic            cf_valid,
  input  logic            cf_ack,
  output logic [XLEN-1:0] cf_target,
  output logic            busy,
  output logic [CW-1:0]   perf_wb_cnt,
  output logic [CW-1:0]   perf_ex_cnt,
  output logic [CW-1:0]   perf_sq_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;
  typedef enum logic {SRC_EX, SRC_WB} src_t;

  state_t          state, state_nxt;
  src_t            src, src_nxt;
  logic [XLEN-1:0] buf_target, buf_target_nxt;
  logic            retire;
  logic            squash;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state      <= IDLE;
      src        <= SRC_EX;
      buf_target <= '0;
    end else begin
      state      <= state_nxt;
      src        <= src_nxt;
      buf_target <= buf_target_nxt;
    end
  end

  // The buffer is open to new requests when empty or retiring this cycle;
  // otherwise only a writeback may displace a pending execute redirect.
  always_comb begin
    state_nxt      = state;
    src_nxt        = src;
    buf_target_nxt = buf_target;
    wb_req_ack     = 1'b0;
    ex_req_ack     = 1'b0;
    retire         = (state == HOLD) && cf_ack;
    squash         = 1'b0;

    if (!g_reset) begin
      if ((state == IDLE) || retire) begin
        wb_req_ack = wb_req_valid;
        ex_req_ack = ex_req_valid && !wb_req_valid;
      end else if (src == SRC_EX) begin
        wb_req_ack = wb_req_valid;
        squash     = wb_req_valid;
      end
    end

    if (wb_req_ack) begin
      state_nxt      = HOLD;
      src_nxt        = SRC_WB;
      buf_target_nxt = wb_req_target;
    end else if (ex_req_ack) begin
      state_nxt      = HOLD;
      src_nxt        = SRC_EX;
      buf_target_nxt = ex_req_target;
    end else if (retire) begin
      state_nxt = IDLE;
    end
  end

  assign cf_valid  = (state == HOLD);
  assign busy      = cf_valid;
  assign cf_target = buf_target;

`ifdef CORE_CF_ARB_PERF_EN
  logic [CW-1:0] wb_cnt, ex_cnt, sq_cnt;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      wb_cnt <= '0;
      ex_cnt <= '0;
      sq_cnt <= '0;
    end else begin
      if (retire && (src == SRC_WB) && (wb_cnt != '1)) wb_cnt <= wb_cnt + CW'(1);
      if (retire && (src == SRC_EX) && (ex_cnt != '1)) ex_cnt <= ex_cnt + CW'(1);
      if (squash && (sq_cnt != '1)) sq_cnt <= sq_cnt + CW'(1);
    end
  end

  assign perf_wb_cnt = wb_cnt;
  assign perf_ex_cnt = ex_cnt;
  assign perf_sq_cnt = sq_cnt;
`else
  assign perf_wb_cnt = '0;
  assign perf_ex_cnt = '0;
  assign perf_sq_cnt = '0;
`endif

endmodule
